// File: rtl/univ_shift_reg_amisha.sv
// Universal N-bit register/shift register with single-cycle ops and a
// self-timed burst mode that repeats a shift/rotate for a programmed count.
module univ_shift_reg_amisha #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk_amisha,
   input  logic             reset_amisha,
   input  logic             en_amisha,
   input  logic [2:0]       mode_amisha,
   input  logic [WIDTH-1:0] d_amisha,
   input  logic             sr_in_amisha,
   input  logic             sl_in_amisha,
   input  logic             start_amisha,
   input  logic [LEN_W-1:0] len_amisha,
   output logic [WIDTH-1:0] q_amisha,
   output logic             so_left_amisha,
   output logic             so_right_amisha,
   output logic             busy_amisha,
   output logic             done_amisha
);

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_LOAD = 3'b001,
      OP_SHR  = 3'b010,
      OP_SHL  = 3'b011,
      OP_ROR  = 3'b100,
      OP_ROL  = 3'b101,
      OP_ASR  = 3'b110,
      OP_CLR  = 3'b111
   } op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state, state_next;
   op_t              op_reg, op_next;
   logic [LEN_W-1:0] cnt, cnt_next;
   logic [WIDTH-1:0] q_next;
   logic             done_next;

   function automatic logic [WIDTH-1:0] apply_op(
      input op_t              op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sr,
      input logic             sl
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         OP_HOLD: res = cur;
         OP_LOAD: res = din;
         OP_SHR:  res = {sr, cur[WIDTH-1:1]};
         OP_SHL:  res = {cur[WIDTH-2:0], sl};
         OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
         OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         OP_CLR:  res = '0;
         default: res = cur;
      endcase
      return res;
   endfunction

   always_comb begin
      state_next = state;
      op_next    = op_reg;
      cnt_next   = cnt;
      q_next     = q_amisha;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start_amisha) begin
               op_next = op_t'(mode_amisha);
               // Only the shift/rotate ops are worth repeating; anything else completes at once.
               if ((mode_amisha inside {[3'b010:3'b110]}) && (len_amisha != '0)) begin
                  state_next = BURST;
                  cnt_next   = len_amisha;
               end else begin
                  done_next = 1'b1;
               end
            end else if (en_amisha) begin
               q_next = apply_op(op_t'(mode_amisha), q_amisha, d_amisha,
                                 sr_in_amisha, sl_in_amisha);
            end
         end
         BURST: begin
            q_next   = apply_op(op_reg, q_amisha, d_amisha, sr_in_amisha, sl_in_amisha);
            cnt_next = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) begin
         state       <= IDLE;
         op_reg      <= OP_HOLD;
         cnt         <= '0;
         q_amisha    <= '0;
         done_amisha <= 1'b0;
      end else begin
         state       <= state_next;
         op_reg      <= op_next;
         cnt         <= cnt_next;
         q_amisha    <= q_next;
         done_amisha <= done_next;
      end
   end

   assign busy_amisha     = (state == BURST);
   assign so_left_amisha  = q_amisha[WIDTH-1];
   assign so_right_amisha = q_amisha[0];

endmodule

// File: doc/univ_shift_reg_amisha.md
Name: univ_shift_reg_amisha

Overview:
- Parametrised universal register and shift register; the next generation of the single-bit D flip-flop.
- Provides N-bit storage with hold, parallel load, logical, arithmetic and rotate shifts, and serial in/out.
- Adds a self-timed burst mode: one start pulse runs a shift or rotate for a programmable number of cycles.
- Used as the general storage/serialiser primitive in sequential-circuit designs.

Parameters:
- WIDTH, 8: register width in bits (≥2).
- LEN_W, 4: width of the burst length field; maximum burst is 2^LEN_W−1 cycles.

Ports:
- clk_amisha  in  1  clock; all state changes on the rising edge.
- reset_amisha  in  1  synchronous reset, active-high.
- en_amisha  in  1  enables single-cycle mode operations; ignored while busy.
- mode_amisha  in  3  operation select (see Behaviour).
- d_amisha  in  WIDTH  parallel load data.
- sr_in_amisha  in  1  serial input to the MSB on shift right.
- sl_in_amisha  in  1  serial input to the LSB on shift left.
- start_amisha  in  1  burst start request.
- len_amisha  in  LEN_W  burst length, sampled at start.
- q_amisha  out  WIDTH  register contents.
- so_left_amisha  out  1  combinational q_amisha[WIDTH-1].
- so_right_amisha  out  1  combinational q_amisha[0].
- busy_amisha  out  1  high while a burst runs.
- done_amisha  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset, synchronous, highest priority over everything:
  - q=0, busy=0, done=0, state IDLE, burst counter 0.
  - Reset asserted mid-burst aborts the burst; no done pulse.
- Mode encoding:
  - 000 hold.
  - 001 load d.
  - 010 shift right: q <= {sr_in, q[W-1:1]}.
  - 011 shift left: q <= {q[W-2:0], sl_in}.
  - 100 rotate right: q <= {q[0], q[W-1:1]}.
  - 101 rotate left: q <= {q[W-2:0], q[W-1]}.
  - 110 arithmetic shift right: q <= {q[W-1], q[W-1:1]}.
  - 111 clear: q <= 0.
- IDLE state:
  - If start=1, go to BURST; start has priority over en in the same cycle.
  - If en=1 and start=0, apply mode to q at the edge, 1-cycle latency.
  - If en=0 and start=0, q holds.
  - done=0 except as noted below.
- Burst start (IDLE, start=1):
  - Latch the mode and len; q is unchanged on the start edge.
  - If the latched mode is 010–110 and len≠0: state becomes BURST, busy=1, counter=len.
  - If len=0 or the mode is 000/001/111: stay IDLE, busy stays 0, done=1 for the next cycle, q unchanged.
- BURST state:
  - Each edge applies the latched op using the live sr_in/sl_in, and the counter decrements.
  - The edge on which the counter goes 1→0 performs the last op, returns to IDLE, clears busy and sets done=1 for exactly one cycle.
  - en, mode, d, len and start are ignored while busy; start during BURST is dropped, not queued.
- Burst timing: busy is high for exactly len cycles and q has changed exactly len times when done is seen.
- A start in the cycle where done=1, with state IDLE, is accepted normally, so bursts can run back-to-back.
- Serial outputs are pure functions of q; there is no extra latency.

Test Plan (WIDTH=8, LEN_W=4):
- Reset held 2 cycles with en=1, mode=001, d=FF → q=00, busy=0, done=0; release, load A5 → q=A5 after 1 edge.
- q=A5, mode=010, sr_in=1, en=1, one edge → q=D2, so_right=0, so_left=1; en=0 for 3 edges → q stays D2.
- q=81, mode=101, one edge → q=03; q=80, mode=110, two edges → q=C0 then E0; mode=100 on 01 → 80.
- q=01, start with mode=011, sl_in=0, len=3 → busy=1 for 3 cycles, q 02→04→08, done=1 for one cycle with q=08; mode=111 with en=1 pulsed during the burst → no effect.
- Start with len=0 → no busy, done pulse next cycle, q unchanged. Start with mode=001 → same behaviour. Start in the done cycle → a new burst runs.
- Burst len=15 rotate right on 01; assert reset after 5 busy cycles → next cycle q=00, busy=0, no done pulse ever.
